// File: rtl/threetoeight_buf.sv
`default_nettype none
// ============================================================================
//  Module   : threetoeight_buf
//  Purpose  : Buffered 3-to-8 decoder. Binary codes are accepted on a
//             valid/ready input handshake and queued in a DEPTH-entry FIFO.
//             Each code is presented in order as a registered one-hot word
//             on a valid/ready output handshake.
//  Ports    : clk        - rising-edge clock
//             rst_n      - synchronous reset, active low
//             in         - 3-bit binary code
//             in_valid   - in carries a code to transfer
//             in_ready   - block accepts a code this cycle
//             out        - one-hot decode of head code, zero when idle
//             out_valid  - out holds a word
//             out_ready  - consumer takes out this cycle
//             count      - FIFO occupancy, not counting the output register
//  Revision : 1.0 - initial release
// ============================================================================
module threetoeight_buf #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              c_PTR_W = $clog2(DEPTH);
    localparam int              c_CNT_W = c_PTR_W + 1;
    localparam [c_CNT_W-1:0]    c_FULL  = c_CNT_W'(DEPTH);

    logic [2:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [7:0]          r_out;
    logic                r_out_valid;

    logic                w_push;
    logic                w_load;
    logic                w_clear;
    logic [7:0]          w_dec;

    // in_ready depends on count alone; a load in the same cycle does not
    // open a slot early.
    assign in_ready = (r_count < c_FULL);
    assign w_push   = in_valid && in_ready;

    // The output register refills whenever it is empty or being drained.
    assign w_load   = (r_count != '0) && (!r_out_valid || out_ready);

    // Drained with nothing queued behind it: the word goes away.
    assign w_clear  = r_out_valid && out_ready && (r_count == '0);

    assign w_dec    = 8'd1 << r_mem[r_rd_ptr];

    // Storage array carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
        end else if (w_load) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out       <= 8'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out       <= w_dec;
            r_out_valid <= 1'b1;
        end else if (w_clear) begin
            r_out       <= 8'b0;
            r_out_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign count     = r_count;

endmodule
`default_nettype wire
